// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_pkg : shared encodings for the handshaked sequential ALU     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package alu_seq_pkg;

  localparam logic [1:0] PRE_PASS = 2'b00;
  localparam logic [1:0] PRE_ZERO = 2'b01;
  localparam logic [1:0] PRE_INV  = 2'b10;

  typedef enum logic {
    MODE_LA  = 1'b0,
    MODE_MUL = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam int SEL_XPRE_MSB = 5;
  localparam int SEL_XPRE_LSB = 4;
  localparam int SEL_YPRE_MSB = 3;
  localparam int SEL_YPRE_LSB = 2;
  localparam int SEL_FUNC     = 1;
  localparam int SEL_INV      = 0;

endpackage
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_core : AND/ADD function, output invert and result flags      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module alu_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             func_i,
  input  logic             inv_i,
  input  logic             mul_en_i,
  input  logic [WIDTH-1:0] mul_r_i,
  input  logic             mul_ov_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             co_o,
  output logic             ov_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  // Carry and overflow describe r itself, before the optional inversion.
  always_comb begin
    r    = a_i & b_i;
    co_o = 1'b0;
    ov_o = 1'b0;
    if (mul_en_i) begin
      r    = mul_r_i;
      ov_o = mul_ov_i;
    end else if (func_i) begin
      r    = sum[WIDTH-1:0];
      co_o = sum[WIDTH];
      ov_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    end
  end

  assign out_o = inv_i ? ~r : r;
  assign zr_o  = (out_o == '0);
  assign ng_o  = out_o[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq  : handshaked Hack-style ALU with iterative signed multiply  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       select,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             co,
  output logic             ov
);

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 2);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic               inv_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_q;
  logic               zr_q, ng_q, co_q, ov_q;

  logic [WIDTH-1:0]   a, b, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_d, prod;
  logic               mul_ov, fin, out_take, hs;
  logic [WIDTH-1:0]   core_out;
  logic               core_zr, core_ng, core_co, core_ov;

  function automatic logic [WIDTH-1:0] pre_op(input logic [WIDTH-1:0] v, input logic [1:0] op);
    case (op)
      PRE_PASS: return v;
      PRE_INV:  return ~v;
      default:  return '0;
    endcase
  endfunction

  assign a     = pre_op(x, select[SEL_XPRE_MSB:SEL_XPRE_LSB]);
  assign b     = pre_op(y, select[SEL_YPRE_MSB:SEL_YPRE_LSB]);
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // The final shift-add step is folded into FIN, so acc_d there is the full magnitude product.
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod   = neg_q ? -acc_d : acc_d;
  assign mul_ov = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  assign fin    = (state_q == S_FIN);

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a),
    .b_i      (b),
    .func_i   (select[SEL_FUNC]),
    .inv_i    (fin ? inv_q : select[SEL_INV]),
    .mul_en_i (fin),
    .mul_r_i  (prod[WIDTH-1:0]),
    .mul_ov_i (mul_ov),
    .out_o    (core_out),
    .zr_o     (core_zr),
    .ng_o     (core_ng),
    .co_o     (core_co),
    .ov_o     (core_ov)
  );

  assign out_take = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_take && !reset;
  assign hs       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            if (mode_e'(mode) == MODE_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, a_mag};
              mplier_q <= b_mag;
              neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
              inv_q    <= select[SEL_INV];
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              out_q       <= core_out;
              zr_q        <= core_zr;
              ng_q        <= core_ng;
              co_q        <= core_co;
              ov_q        <= core_ov;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= S_FIN;
        end
        S_FIN: begin
          if (out_take) begin
            out_q       <= core_out;
            zr_q        <= core_zr;
            ng_q        <= core_ng;
            co_q        <= core_co;
            ov_q        <= core_ov;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign co        = co_q;
  assign ov        = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq : directed vector table plus stall and reset sequences    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_alu_seq;

  localparam int W = 16;
  localparam int NV = 18;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, mode, out_valid, out_ready;
  logic         zr, ng, co, ov;
  logic [W-1:0] x, y, out;
  logic [5:0]   select;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected flags packed as {zr, ng, co, ov}.
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   sel;
    logic         mode;
    logic [W-1:0] e_out;
    logic [3:0]   e_flg;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .select    (select),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .co        (co),
    .ov        (ov)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int rdy_seen;
    @(negedge clk);
    x = v.x; y = v.y; select = v.sel; mode = v.mode;
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen++;
      @(negedge clk); lat++;
    end
    check($sformatf("v%0d busy_in_ready", idx), rdy_seen, 0);
    check($sformatf("v%0d latency", idx), lat, v.mode ? W + 1 : 1);
    check($sformatf("v%0d out", idx), {16'd0, out}, {16'd0, v.e_out});
    check($sformatf("v%0d flags", idx), {28'd0, zr, ng, co, ov}, {28'd0, v.e_flg});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d drained", idx), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;

    vecs[0]  = '{16'h0005, 16'h0003, 6'b000010, 1'b0, 16'h0008, 4'b0000};
    vecs[1]  = '{16'h7FFF, 16'h0001, 6'b000010, 1'b0, 16'h8000, 4'b0101};
    vecs[2]  = '{16'hFFFF, 16'h0001, 6'b000010, 1'b0, 16'h0000, 4'b1010};
    vecs[3]  = '{16'h00F0, 16'h0F3C, 6'b000000, 1'b0, 16'h0030, 4'b0000};
    vecs[4]  = '{16'h00FF, 16'h0F0F, 6'b100000, 1'b0, 16'h0F00, 4'b0000};
    vecs[5]  = '{16'h1234, 16'h5678, 6'b010101, 1'b0, 16'hFFFF, 4'b0100};
    vecs[6]  = '{16'h1234, 16'h0005, 6'b110010, 1'b0, 16'h0005, 4'b0000};
    vecs[7]  = '{16'h0005, 16'h0003, 6'b001010, 1'b0, 16'h0001, 4'b0010};
    vecs[8]  = '{16'h8000, 16'hFFFF, 6'b000010, 1'b0, 16'h7FFF, 4'b0011};
    vecs[9]  = '{16'h0002, 16'h0003, 6'b000011, 1'b0, 16'hFFFA, 4'b0100};
    vecs[10] = '{16'hFFFD, 16'h0007, 6'b000000, 1'b1, 16'hFFEB, 4'b0100};
    vecs[11] = '{16'h012C, 16'h012C, 6'b000000, 1'b1, 16'h5F90, 4'b0001};
    vecs[12] = '{16'h012C, 16'h012C, 6'b000001, 1'b1, 16'hA06F, 4'b0101};
    vecs[13] = '{16'h8000, 16'h0001, 6'b000000, 1'b1, 16'h8000, 4'b0100};
    vecs[14] = '{16'h8000, 16'hFFFF, 6'b000000, 1'b1, 16'h8000, 4'b0101};
    vecs[15] = '{16'h1234, 16'h0000, 6'b000010, 1'b1, 16'h0000, 4'b1000};
    vecs[16] = '{16'h0005, 16'h0004, 6'b100010, 1'b1, 16'hFFE8, 4'b0100};
    vecs[17] = '{16'hFFFE, 16'hFFFD, 6'b000000, 1'b1, 16'h0006, 4'b0000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; select = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready low", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out", {16'd0, out}, 32'd0);
    check("reset flags", {28'd0, zr, ng, co, ov}, 32'd0);
    check("reset in_ready high", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Output stall: result held for 5 cycles, next operand waits, then same-cycle accept.
    @(negedge clk);
    x = 16'd5; y = 16'd3; select = 6'b000010; mode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    x = 16'd1; y = 16'd2;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d hold", k), {out_valid, 10'd0, out, zr, ng, co, ov},
            {1'b1, 10'd0, 16'h0008, 4'b0000});
      check($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall next valid", {31'd0, out_valid}, 32'd1);
    check("stall next out", {16'd0, out}, 32'h0003);
    @(negedge clk);
    out_ready = 1'b0;
    check("stall drained", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply: no result may surface afterwards.
    @(negedge clk);
    x = 16'h012C; y = 16'h012C; select = 6'b000000; mode = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mul busy in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midmul out_valid", {31'd0, out_valid}, 32'd0);
    check("midmul out", {16'd0, out}, 32'd0);
    check("midmul flags", {28'd0, zr, ng, co, ov}, 32'd0);
    check("midmul in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midmul no stale result", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
